mac_psum_reader: RTL

MAC_PSUM_READER -- requirements
Module: mac_psum_reader

---
 rtl/mac_pkg.sv | 16 +
 rtl/psum_fifo.sv | 60 ++++++
 rtl/mac_psum_reader.sv | 80 ++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared defaults and helpers for the MAC partial-sum reader and its benches.
package mac_pkg;

  localparam int psum_bw_default = 16;
  localparam int len_default     = 10;
  localparam int depth_default   = 4;

  // Ceiling log2, never below 1 so a 1-entry range still gets a real register bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// Result FIFO for completed vector sums: show-ahead read, simultaneous push/pop allowed when full.
module psum_fifo
  import mac_pkg::*;
#(
  parameter int psum_bw = psum_bw_default,
  parameter int depth   = depth_default
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full
);

  localparam int aw = clog2(depth);
  localparam logic [aw:0] full_count = (aw + 1)'(depth);
  localparam logic [aw:0] one_count  = (aw + 1)'(1);
  localparam logic [aw-1:0] one_ptr  = aw'(1);

  logic [psum_bw-1:0] mem [depth];
  logic [aw-1:0]      wr_ptr;
  logic [aw-1:0]      rd_ptr;
  logic [aw:0]        count;
  logic               do_push;
  logic               do_pop;

  assign empty = (count == '0);
  assign full  = (count == full_count);
  assign dout  = mem[rd_ptr];

  // A push while full only lands if the same edge frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + one_ptr;
      if (do_pop)  rd_ptr <= rd_ptr + one_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + one_count;
        2'b01:   count <= count - one_count;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_psum_reader.sv
// Counts MAC beats per vector, feeds the running sum back as c, and queues each vector's final sum.
module mac_psum_reader
  import mac_pkg::*;
#(
  parameter int psum_bw = psum_bw_default,
  parameter int len     = len_default,
  parameter int depth   = depth_default
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [psum_bw-1:0] in_psum,
  output logic [psum_bw-1:0] c_out,
  output logic               first,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_psum,
  output logic               full,
  output logic               ovf
);

  // Output handshake: a result transfers on a rising edge where out_valid and
  // out_ready are both 1; out_psum holds while out_valid=1 and out_ready=0, and
  // out_ready has no effect while out_valid=0. The input side has no ready.

  localparam int cnt_w = clog2(len);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(len - 1);
  localparam logic [cnt_w-1:0] one_beat  = cnt_w'(1);

  logic [cnt_w-1:0] beat_cnt;
  logic             final_beat;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;

  assign final_beat = in_valid && (beat_cnt == last_beat);
  assign pop        = out_valid && out_ready;
  assign first      = (beat_cnt == '0);
  assign out_valid  = !fifo_empty;
  assign full       = fifo_full;

  // The feedback returns to 0 on the final beat so the next vector starts from c=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
      c_out    <= '0;
    end else if (in_valid) begin
      if (final_beat) begin
        beat_cnt <= '0;
        c_out    <= '0;
      end else begin
        beat_cnt <= beat_cnt + one_beat;
        c_out    <= in_psum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (final_beat && fifo_full && !pop) begin
      ovf <= 1'b1;
    end
  end

  psum_fifo #(
    .psum_bw (psum_bw),
    .depth   (depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (final_beat),
    .pop   (pop),
    .din   (in_psum),
    .dout  (out_psum),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule
